// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// Round-robin grant, latched request copies, WAIT extra access cycles, one-cycle done pulse.

module mem_port_arbiter #(
  parameter int WAIT = 1,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       w_grantData;

  // On a tie the port that was not served last wins; r_last=0 means fetch was last.
  assign w_grantData = dm_req && (!if_req || !r_last);

  // mem_addr/mem_wdata/mem_we double as the latched request copies for the whole access.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_last    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_req || dm_req) begin
            r_state <= ACCESS;
            r_cnt   <= 4'd0;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            if (w_grantData) begin
              owner     <= 1'b1;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_we    <= dm_we;
            end else begin
              owner    <= 1'b0;
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == WAIT_C) begin
            r_state <= RESP;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            r_last  <= owner;
            if (owner) begin
              dm_done <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          if_done <= 1'b0;
          dm_done <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of order, timing and data.
// A second instance with WAIT=0 covers the zero-wait-state path.

module tb_mem_port_arbiter;

  localparam int WAIT = 1;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        ifReq, ifDone, dmReq, dmWe, dmDone;
  logic [31:0] ifAddr, ifRdata, dmAddr, dmWdata, dmRdata;
  logic        memEn, memWe, busy, owner;
  logic [31:0] memAddr, memWdata, memRdata;

  logic        ifReq0, ifDone0, dmReq0, dmWe0, dmDone0;
  logic [31:0] ifAddr0, ifRdata0, dmAddr0, dmWdata0, dmRdata0;
  logic        memEn0, memWe0, busy0, owner0;
  logic [31:0] memAddr0, memWdata0, memRdata0;

  logic [31:0] memArray [0:255];
  logic [31:0] refMem   [0:255];
  bit          memInit = 1'b0;

  int          checkCount = 0;
  int          errorCount = 0;
  bit          refLast;
  logic [31:0] refIfRdata, refDmRdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.WAIT(WAIT), .AW(32), .DW(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_done(ifDone), .if_rdata(ifRdata),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_done(dmDone), .dm_rdata(dmRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.WAIT(0), .AW(32), .DW(32)) dut0 (
    .CLK(CLK), .Reset(Reset),
    .if_req(ifReq0), .if_addr(ifAddr0), .if_done(ifDone0), .if_rdata(ifRdata0),
    .dm_req(dmReq0), .dm_we(dmWe0), .dm_addr(dmAddr0), .dm_wdata(dmWdata0),
    .dm_done(dmDone0), .dm_rdata(dmRdata0),
    .mem_en(memEn0), .mem_we(memWe0), .mem_addr(memAddr0), .mem_wdata(memWdata0),
    .mem_rdata(memRdata0), .busy(busy0), .owner(owner0)
  );

  function automatic logic [31:0] patternWord(input int i);
    if (i == 1) return 32'h8C22_0000;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Word-addressed memory: combinational read, write on the clock edge while enabled.
  assign memRdata  = memArray[memAddr[9:2]];
  assign memRdata0 = memArray[memAddr0[9:2]];

  always @(posedge CLK) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) memArray[i] <= patternWord(i);
      memInit <= 1'b1;
    end else if (memEn && memWe) begin
      memArray[memAddr[9:2]] <= memWdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] randAddr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // One round: selected ports raise requests together; model predicts order, done timing and data.
  task automatic applyStimulus(input bit doF, input bit doD, input bit dWe,
                               input logic [31:0] fAddr, input logic [31:0] dAddr,
                               input logic [31:0] dWdata);
    bit dataFirst;
    int expF, expD;
    int seenF = -1;
    int seenD = -1;
    int enCount = 0;
    int weCount = 0;
    bit bothDone = 1'b0;

    dataFirst = doD && (!doF || !refLast);
    expF = -1;
    expD = -1;
    if (doF && doD) begin
      expD = dataFirst ? WAIT + 1 : 2 * WAIT + 4;
      expF = dataFirst ? 2 * WAIT + 4 : WAIT + 1;
    end else if (doF) begin
      expF = WAIT + 1;
    end else if (doD) begin
      expD = WAIT + 1;
    end

    for (int s = 0; s < 2; s++) begin
      bit isData;
      isData = (s == 0) ? dataFirst : !dataFirst;
      if (isData && doD) begin
        if (dWe) refMem[dAddr[9:2]] = dWdata;
        else     refDmRdata = refMem[dAddr[9:2]];
        refLast = 1'b1;
      end else if (!isData && doF) begin
        refIfRdata = refMem[fAddr[9:2]];
        refLast = 1'b0;
      end
    end

    @(posedge CLK); #1;
    ifReq = doF; ifAddr = fAddr;
    dmReq = doD; dmWe = dWe; dmAddr = dAddr; dmWdata = dWdata;

    for (int n = 0; n < 40 && (ifReq || dmReq); n++) begin
      @(posedge CLK); #1;
      if (memEn) enCount++;
      if (memWe) weCount++;
      if (n == 1) begin
        if (dataFirst) begin
          dmAddr = randAddr();
          dmWdata = $urandom;
        end else begin
          ifAddr = randAddr();
        end
      end
      if (ifDone && dmDone) bothDone = 1'b1;
      if (ifDone) begin seenF = n; ifReq = 1'b0; end
      if (dmDone) begin seenD = n; dmReq = 1'b0; end
    end
    ifReq = 1'b0;
    dmReq = 1'b0;

    checkOutput("ifDoneCycle", 32'(seenF), 32'(expF));
    checkOutput("dmDoneCycle", 32'(seenD), 32'(expD));
    checkOutput("donesExclusive", 32'(bothDone), 32'd0);
    checkOutput("memEnCycles", 32'(enCount), 32'((32'(doF) + 32'(doD)) * (WAIT + 1)));
    checkOutput("memWeCycles", 32'(weCount), (doD && dWe) ? 32'(WAIT + 1) : 32'd0);
    checkOutput("ifRdata", ifRdata, refIfRdata);
    checkOutput("dmRdata", dmRdata, refDmRdata);

    @(posedge CLK); #1;
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("ownerHeld", 32'(owner), 32'(refLast));
    checkOutput("ifRdataHeld", ifRdata, refIfRdata);
  endtask

  initial begin
    int dmDoneSeen;
    for (int i = 0; i < 256; i++) refMem[i] = patternWord(i);
    refLast = 1'b0;
    refIfRdata = '0;
    refDmRdata = '0;
    Reset = 1'b1;
    ifReq = 0; ifAddr = '0; dmReq = 0; dmWe = 0; dmAddr = '0; dmWdata = '0;
    ifReq0 = 0; ifAddr0 = '0; dmReq0 = 0; dmWe0 = 0; dmAddr0 = '0; dmWdata0 = '0;
    #22;
    checkOutput("rstMemEn", 32'(memEn), 32'd0);
    checkOutput("rstMemWe", 32'(memWe), 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'd0);
    checkOutput("rstMemWdata", memWdata, 32'd0);
    checkOutput("rstDones", {30'd0, ifDone, dmDone}, 32'd0);
    checkOutput("rstIfRdata", ifRdata, 32'd0);
    checkOutput("rstDmRdata", dmRdata, 32'd0);
    checkOutput("rstBusyOwner", {30'd0, busy, owner}, 32'd0);
    Reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0);
    checkOutput("fetchWord", ifRdata, 32'h8C22_0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0);
    checkOutput("readBack", dmRdata, 32'hDEAD_BEEF);

    for (int r = 0; r < 3; r++)
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), randAddr(), randAddr(), $urandom);

    // Reset during the second access cycle of a write.
    @(posedge CLK); #1;
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h80; dmWdata = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checkOutput("preRstMemWe", 32'(memWe), 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("midRstMemEn", 32'(memEn), 32'd0);
    checkOutput("midRstMemWe", 32'(memWe), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    Reset = 1'b0;
    dmReq = 1'b0;
    dmDoneSeen = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK); #1;
      if (dmDone) dmDoneSeen++;
    end
    checkOutput("noDoneAfterRst", 32'(dmDoneSeen), 32'd0);
    refMem[32] = 32'hCAFE_F00D;
    refLast = 1'b0;
    refIfRdata = '0;
    refDmRdata = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, randAddr(), 32'h80, 32'h0);
    checkOutput("postRstRead", dmRdata, 32'hCAFE_F00D);

    for (int r = 0; r < 30; r++) begin
      int mode;
      mode = $urandom_range(1, 3);
      applyStimulus(1'(mode != 2), 1'(mode != 1), 1'($urandom_range(0, 1)),
                    randAddr(), randAddr(), $urandom);
    end

    // Zero wait states: one access cycle, done two cycles after the request edge.
    @(posedge CLK); #1;
    dmReq0 = 1'b1; dmWe0 = 1'b0; dmAddr0 = 32'h20;
    @(posedge CLK); #1;
    checkOutput("w0MemEn", 32'(memEn0), 32'd1);
    dmAddr0 = 32'h40;
    #1;
    checkOutput("w0AddrLatched", memAddr0, 32'h20);
    @(posedge CLK); #1;
    checkOutput("w0MemEnOff", 32'(memEn0), 32'd0);
    checkOutput("w0Done", 32'(dmDone0), 32'd1);
    checkOutput("w0Rdata", dmRdata0, refMem[8]);
    dmReq0 = 1'b0;
    @(posedge CLK); #1;
    checkOutput("w0DonePulse", 32'(dmDone0), 32'd0);
    checkOutput("w0BusyIdle", 32'(busy0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
